// File: rtl/idct_col_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | idct_col_sequencer : 8x8 transpose buffer feeding the IDCT column core,   |
// |                      pixel output buffer and row-wise drain.              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module idct_col_sequencer #(
  parameter int COEF_W = 11,
  parameter int PIX_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*COEF_W-1:0] in_data,
  output logic [8*COEF_W-1:0] core_in,
  input  logic [8*PIX_W-1:0]  core_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*PIX_W-1:0]  out_data,
  output logic                busy,
  output logic                block_done
);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

  localparam logic [2:0] c_LAST = 3'd7;

  state_e            state_q;
  logic [2:0]        row_cnt_q;
  logic [2:0]        col_cnt_q;
  logic [2:0]        out_cnt_q;
  logic [COEF_W-1:0] tbuf_q [8][8];
  logic [PIX_W-1:0]  obuf_q [8][8];

  logic w_in_fire;
  logic w_out_fire;

  assign in_ready   = (state_q == S_LOAD);
  assign out_valid  = (state_q == S_DRAIN);
  assign busy       = (state_q == S_COMPUTE) || (state_q == S_DRAIN);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign block_done = w_out_fire && (out_cnt_q == c_LAST) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      out_cnt_q <= '0;
    end else if (clear) begin
      state_q   <= S_LOAD;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            row_cnt_q <= row_cnt_q + 3'd1;
            if (row_cnt_q == c_LAST) state_q <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          col_cnt_q <= col_cnt_q + 3'd1;
          if (col_cnt_q == c_LAST) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready) begin
            out_cnt_q <= out_cnt_q + 3'd1;
            if (out_cnt_q == c_LAST) state_q <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_in_fire && !clear) begin
      for (int j = 0; j < 8; j++) begin
        tbuf_q[row_cnt_q][j] <= in_data[(7-j)*COEF_W +: COEF_W];
      end
    end
    if ((state_q == S_COMPUTE) && !clear) begin
      for (int r = 0; r < 8; r++) begin
        obuf_q[r][col_cnt_q] <= core_out[(7-r)*PIX_W +: PIX_W];
      end
    end
  end

  for (genvar r = 0; r < 8; r++) begin : g_core_in
    assign core_in[(7-r)*COEF_W +: COEF_W] =
      (state_q == S_COMPUTE) ? tbuf_q[r][col_cnt_q] : '0;
  end

  for (genvar c = 0; c < 8; c++) begin : g_out_data
    assign out_data[(7-c)*PIX_W +: PIX_W] = out_valid ? obuf_q[out_cnt_q][c] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_idct_col_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_idct_col_sequencer : self-checking bench with a per-element core stub.|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_idct_col_sequencer;

  localparam int COEF_W = 11;
  localparam int PIX_W  = 8;
  localparam int IW     = 8*COEF_W;
  localparam int OW     = 8*PIX_W;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic [IW-1:0] core_in;
  logic [OW-1:0] core_out;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          block_done;

  idct_col_sequencer #(.COEF_W(COEF_W), .PIX_W(PIX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .core_in    (core_in),
    .core_out   (core_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .block_done (block_done)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Stand-in core: each element scaled by 181/512 with round-half-up, clipped to 0..255.
  function automatic logic [7:0] core_px(input logic signed [10:0] x);
    int v;
    v = (181 * int'(x) + 256) >>> 9;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  always_comb begin
    core_out = '0;
    for (int r = 0; r < 8; r++) begin
      core_out[(7-r)*PIX_W +: PIX_W] = core_px(core_in[(7-r)*COEF_W +: COEF_W]);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  int            cyc = 0;
  int            t_last = -1;
  int            in_cnt = 0;
  int            out_idx = 0;
  int            done_cnt = 0;
  logic [IW-1:0] cap [8];
  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] last_row;
  logic [OW-1:0] held;
  bit            hold_chk = 0;

  function automatic logic [IW-1:0] col_vec(input int k);
    logic [IW-1:0] v;
    for (int r = 0; r < 8; r++) v[(7-r)*COEF_W +: COEF_W] = cap[r][(7-k)*COEF_W +: COEF_W];
    return v;
  endfunction

  function automatic logic [OW-1:0] exp_row(input int r);
    logic [OW-1:0] v;
    for (int c = 0; c < 8; c++) v[(7-c)*PIX_W +: PIX_W] = core_px(cap[r][(7-c)*COEF_W +: COEF_W]);
    return v;
  endfunction

  always @(negedge clk) begin
    int   k;
    bit   exp_done;
    logic [OW-1:0] e;
    cyc++;
    if (!rst_n) begin
      t_last = -1; in_cnt = 0; out_idx = 0; hold_chk = 0;
      exp_q.delete();
    end else begin
      chk("in_ready", in_ready, t_last < 0);
      chk("busy", busy, t_last >= 0);
      chk("out_valid", out_valid, (t_last >= 0) && (cyc >= t_last + 9));
      k = cyc - t_last - 1;
      if ((t_last >= 0) && (k >= 0) && (k < 8)) chk("core_in_col", core_in, col_vec(k));
      else chk("core_in_idle", core_in, '0);
      if (hold_chk && out_valid) chk("out_data_stall", out_data, held);
      hold_chk = out_valid && !out_ready && !clear;
      held     = out_data;
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", out_data, 'x);
        end else begin
          e = exp_q.pop_front();
          chk("out_row", out_data, e);
        end
        last_row = out_data;
        out_idx++;
        if (out_idx == 8) exp_done = 1'b1;
      end
      chk("block_done", block_done, exp_done && !clear);
      if (clear) begin
        t_last = -1; in_cnt = 0; out_idx = 0; hold_chk = 0;
        exp_q.delete();
      end else begin
        if (exp_done) begin
          t_last = -1; out_idx = 0; done_cnt++;
        end
        if (in_valid && in_ready) begin
          cap[in_cnt] = in_data;
          in_cnt++;
          if (in_cnt == 8) begin
            for (int r = 0; r < 8; r++) exp_q.push_back(exp_row(r));
            t_last = cyc;
            in_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- out_ready pattern generator ----------------
  int rdy_mode = 0;
  int rdy_ph   = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 3; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [IW-1:0] rows [8], input int gap);
    bit acc;
    int n;
    for (int i = 0; i < 8; i++) begin
      if (i == gap) begin
        in_valid = 1'b0;
        repeat (3) step();
      end
      in_valid = 1'b1;
      in_data  = rows[i];
      acc = 1'b0;
      n   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        step();
        n++;
        if (!acc && n > 100) begin
          chk("accept_timeout", 1'b0, 1'b1);
          in_valid = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("idle_timeout", 1'b0, 1'b1);
  endtask

  typedef struct {
    logic signed [10:0] e0;
    logic [7:0]         px0;
    logic [7:0]         pxr;
    int                 rdy;
    int                 gap;
  } vec_t;

  vec_t          tbl [6];
  logic [IW-1:0] rows [8];
  logic [IW-1:0] rows_b [8];
  int            done_before;
  int            n;

  initial begin
    tbl[0] = '{e0:  11'sd256,  px0: 8'd91,  pxr: 8'd0, rdy: 0, gap: -1};
    tbl[1] = '{e0: -11'sd256,  px0: 8'd0,   pxr: 8'd0, rdy: 0, gap: -1};
    tbl[2] = '{e0:  11'sd1023, px0: 8'd255, pxr: 8'd0, rdy: 1, gap: 3};
    tbl[3] = '{e0:  11'sd100,  px0: 8'd35,  pxr: 8'd0, rdy: 2, gap: -1};
    tbl[4] = '{e0: -11'sd1024, px0: 8'd0,   pxr: 8'd0, rdy: 1, gap: 5};
    tbl[5] = '{e0:  11'sd600,  px0: 8'd212, pxr: 8'd0, rdy: 0, gap: -1};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_block_done", block_done, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_core_in", core_in, '0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 6; t++) begin
      rdy_mode = tbl[t].rdy;
      for (int r = 0; r < 8; r++) rows[r] = {tbl[t].e0, 77'd0};
      done_before = done_cnt;
      send_block(rows, tbl[t].gap);
      in_valid = 1'b0;
      wait_idle();
      chk("tbl_last_row", last_row, {tbl[t].px0, {7{tbl[t].pxr}}});
      chk("tbl_done_once", 32'(done_cnt - done_before), 32'd1);
    end

    // Transpose: a single 256 on the diagonal.
    rdy_mode = 0;
    for (int r = 0; r < 8; r++) begin
      rows[r] = '0;
      rows[r][(7-r)*COEF_W +: COEF_W] = 11'd256;
    end
    send_block(rows, -1);
    in_valid = 1'b0;
    wait_idle();
    chk("transpose_row7", last_row, 64'h0000_0000_0000_005B);

    for (int b = 0; b < 3; b++) begin
      rdy_mode = 2;
      for (int r = 0; r < 8; r++)
        for (int j = 0; j < 8; j++) rows[r][j*COEF_W +: COEF_W] = 11'($urandom);
      send_block(rows, (b == 1) ? 2 : -1);
      in_valid = 1'b0;
      wait_idle();
    end

    // Abort during COMPUTE column 4, then a clean block.
    rdy_mode = 0;
    done_before = done_cnt;
    send_block(rows, -1);
    in_valid = 1'b0;
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (12) step();
    chk("abort_no_done", 32'(done_cnt - done_before), 32'd0);
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) rows[r][j*COEF_W +: COEF_W] = 11'($urandom);
    send_block(rows, -1);
    in_valid = 1'b0;
    wait_idle();
    chk("post_abort_done", 32'(done_cnt - done_before), 32'd1);

    // Back-to-back blocks with in_valid held high.
    done_before = done_cnt;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) begin
        rows[r][j*COEF_W +: COEF_W]   = 11'($urandom);
        rows_b[r][j*COEF_W +: COEF_W] = 11'($urandom);
      end
    send_block(rows, -1);
    send_block(rows_b, -1);
    in_valid = 1'b0;
    wait_idle();
    chk("b2b_done", 32'(done_cnt - done_before), 32'd2);

    // Asynchronous reset while DRAIN is stalled.
    rdy_mode = 3;
    send_block(rows, -1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk("drain_reached", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    rdy_mode = 0;
    step();
    done_before = done_cnt;
    send_block(rows_b, -1);
    in_valid = 1'b0;
    wait_idle();
    chk("post_arst_done", 32'(done_cnt - done_before), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
